// File: rtl/seq_alu.sv
// seq_alu: valid/ready ALU with registered result and flags. Multiply and
// divide iterate one bit per cycle; every other op completes at the accept edge.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             carry,
   output logic             ovf,
   output logic             dz
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_XOR
   } op_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;      // multiplicand (mul) or divisor (div)
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;  // partial product high half / remainder
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;  // multiplier / quotient shift register
   logic [WIDTH-1:0] y_q, y_d, hi_q, hi_d;
   logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, dz_q, dz_d;

   op_t              op_e;
   logic [WIDTH:0]   sum, diff, mul_sum, rem_sh, rem_sub;

   assign op_e    = op_t'(op);
   assign sum     = {1'b0, a} + {1'b0, b};
   assign diff    = {1'b0, a} - {1'b0, b};
   assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
   assign rem_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
   // Top bit of rem_sub is the borrow: set when the shifted remainder < divisor.
   assign rem_sub = rem_sh - {1'b0, opnd_q};

   always_comb begin
      // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      opnd_d   = opnd_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      y_d      = y_q;
      hi_d     = hi_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      dz_d     = dz_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (op_e == OP_MUL) begin
                  opnd_d   = a;
                  acc_hi_d = '0;
                  acc_lo_d = b;
                  cnt_d    = CW'(WIDTH);
                  state_d  = MUL;
               end else if (op_e == OP_DIV && b != '0) begin
                  opnd_d   = b;
                  acc_hi_d = '0;
                  acc_lo_d = a;
                  cnt_d    = CW'(WIDTH);
                  state_d  = DIV;
               end else begin
                  state_d = DONE;
                  hi_d    = '0;
                  carry_d = 1'b0;
                  ovf_d   = 1'b0;
                  dz_d    = 1'b0;
                  case (op_e)
                     OP_ADD: begin
                        y_d     = sum[WIDTH-1:0];
                        carry_d = sum[WIDTH];
                        ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                     end
                     OP_SUB: begin
                        y_d     = diff[WIDTH-1:0];
                        carry_d = diff[WIDTH];
                        ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                     end
                     OP_AND:  y_d = a & b;
                     OP_OR:   y_d = a | b;
                     OP_NOT:  y_d = ~a;
                     OP_XOR:  y_d = a ^ b;
                     default: begin  // only divide-by-zero reaches here
                        y_d  = '1;
                        hi_d = a;
                        dz_d = 1'b1;
                     end
                  endcase
                  zero_d = (y_d == '0);
               end
            end
         end

         MUL: begin
            {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
               y_d     = acc_lo_d;
               hi_d    = acc_hi_d;
               zero_d  = (acc_lo_d == '0);
               carry_d = (acc_hi_d != '0);
               ovf_d   = 1'b0;
               dz_d    = 1'b0;
            end
         end

         DIV: begin
            acc_hi_d = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ~rem_sub[WIDTH]};
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
               y_d     = acc_lo_d;
               hi_d    = acc_hi_d;
               zero_d  = (acc_lo_d == '0);
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               dz_d    = 1'b0;
            end
         end

         DONE: begin
            if (out_ready) state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every register, datapath included, is reset so an aborted mul/div leaves no residue.
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         opnd_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         y_q      <= '0;
         hi_q     <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opnd_q   <= opnd_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         y_q      <= y_d;
         hi_q     <= hi_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         dz_q     <= dz_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign y         = y_q;
   assign hi        = hi_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;
   assign dz        = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH = 8): directed vector table, hand-written backpressure
// and mid-operation reset sequences, then random ops against an arithmetic model.
module tb_seq_alu;
   localparam int W = 8;

   logic         clk, rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] a, b, y, hi;
   logic [2:0]   op;
   logic         zero, carry, ovf, dz;

   int checks = 0;
   int errors = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op),
      .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .hi(hi), .zero(zero), .carry(carry), .ovf(ovf), .dz(dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running, required finished");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [W-1:0] a, b;
      logic [2:0]   op;
      logic [W-1:0] ey, ehi;
      logic [3:0]   ef;    // {zero, carry, ovf, dz}
      int           elat;  // edges from accept to out_valid
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operation's definition.
   task automatic model(input logic [W-1:0] ma, mb, input logic [2:0] mop,
                        output logic [W-1:0] ey, ehi, output logic [3:0] ef, output int elat);
      int ua, ub, sa, sb, r, hr;
      bit c, o, d;
      ua = int'(ma);
      ub = int'(mb);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      r = 0; hr = 0; c = 0; o = 0; d = 0; elat = 0;
      case (mop)
         3'd0: begin r = ua + ub; c = (r > 255); o = (sa + sb > 127) || (sa + sb < -128); end
         3'd1: begin r = ua - ub; c = (ua < ub); o = (sa - sb > 127) || (sa - sb < -128); end
         3'd2: begin r = ua * ub; hr = r / 256; c = (hr != 0); elat = W; end
         3'd3: begin
            if (ub == 0) begin r = 255; hr = ua; d = 1; end
            else begin r = ua / ub; hr = ua % ub; elat = W; end
         end
         3'd4: r = ua & ub;
         3'd5: r = ua | ub;
         3'd6: r = 255 - ua;
         default: r = ua ^ ub;
      endcase
      ey  = W'(r);
      ehi = W'(hr);
      ef  = {ey == '0, c, o, d};
   endtask

   // Runs one transaction: wait for in_ready, present, accept, scramble inputs,
   // wait for out_valid (bounded), capture, then release the result.
   task automatic exec_op(input logic [W-1:0] ta, tbv, input logic [2:0] top,
                          output logic [W-1:0] ry, rhi, output logic [3:0] rf,
                          output int lat, output bit rdy_ok);
      int guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      a = ta; b = tbv; op = top; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); op = 3'($urandom);
      lat = 0;
      rdy_ok = 1'b1;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_ok = 1'b0;
         @(posedge clk); #1; lat++;
      end
      if (!out_valid) lat = -1;
      if (in_ready) rdy_ok = 1'b0;
      ry = y; rhi = hi; rf = {zero, carry, ovf, dz};
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic verify(input string tag, input logic [W-1:0] ta, tbv, input logic [2:0] top,
                         input logic [W-1:0] ey, ehi, input logic [3:0] ef, input int elat);
      logic [W-1:0] ry, rhi;
      logic [3:0]   rf;
      int           lat;
      bit           rdy_ok;
      exec_op(ta, tbv, top, ry, rhi, rf, lat, rdy_ok);
      check({tag, ".y"}, int'(ry), int'(ey));
      check({tag, ".hi"}, int'(rhi), int'(ehi));
      check({tag, ".flags_zcod"}, int'(rf), int'(ef));
      check({tag, ".latency"}, lat, elat);
      check({tag, ".in_ready_low"}, int'(rdy_ok), 1);
   endtask

   initial begin
      vec_t         vecs[$];
      logic [W-1:0] ra, rb, ey, ehi;
      logic [2:0]   rop;
      logic [3:0]   ef;
      int           elat;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; op = '0;

      #2;
      check("rst.y", int'(y), 0);
      check("rst.hi", int'(hi), 0);
      check("rst.flags", int'({zero, carry, ovf, dz}), 0);
      check("rst.out_valid", int'(out_valid), 0);
      #10 rst_n = 1'b1;
      #1 check("rst.in_ready", int'(in_ready), 1);

      vecs.push_back('{8'd7,   8'd3,   3'd0, 8'd10,  8'h00, 4'b0000, 0});
      vecs.push_back('{8'd7,   8'd3,   3'd1, 8'd4,   8'h00, 4'b0000, 0});
      vecs.push_back('{8'd3,   8'd7,   3'd1, 8'hFC,  8'h00, 4'b0100, 0});
      vecs.push_back('{8'd200, 8'd100, 3'd0, 8'd44,  8'h00, 4'b0100, 0});
      vecs.push_back('{8'd127, 8'd1,   3'd0, 8'h80,  8'h00, 4'b0010, 0});
      vecs.push_back('{8'd5,   8'd5,   3'd1, 8'h00,  8'h00, 4'b1000, 0});
      vecs.push_back('{8'h80,  8'h01,  3'd1, 8'h7F,  8'h00, 4'b0010, 0});
      vecs.push_back('{8'd200, 8'd200, 3'd2, 8'h40,  8'h9C, 4'b0100, 8});
      vecs.push_back('{8'd0,   8'd5,   3'd2, 8'h00,  8'h00, 4'b1000, 8});
      vecs.push_back('{8'd7,   8'd3,   3'd3, 8'd2,   8'h01, 4'b0000, 8});
      vecs.push_back('{8'd7,   8'd0,   3'd3, 8'hFF,  8'h07, 4'b0001, 0});
      vecs.push_back('{8'hFF,  8'd1,   3'd3, 8'hFF,  8'h00, 4'b0000, 8});
      vecs.push_back('{8'd5,   8'd200, 3'd3, 8'h00,  8'h05, 4'b1000, 8});
      vecs.push_back('{8'hF0,  8'h0F,  3'd4, 8'h00,  8'h00, 4'b1000, 0});
      vecs.push_back('{8'hA0,  8'h05,  3'd5, 8'hA5,  8'h00, 4'b0000, 0});
      vecs.push_back('{8'd7,   8'h55,  3'd6, 8'hF8,  8'h00, 4'b0000, 0});
      vecs.push_back('{8'hF0,  8'hFF,  3'd7, 8'h0F,  8'h00, 4'b0000, 0});

      foreach (vecs[i])
         verify($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                vecs[i].ey, vecs[i].ehi, vecs[i].ef, vecs[i].elat);

      // Backpressure: result held while out_ready is low; a pending xor waits.
      a = 8'd7; b = 8'h33; op = 3'd6; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp.accept_valid", int'(out_valid), 1);
      a = 8'hF0; b = 8'hFF; op = 3'd7;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp.hold%0d.y", i), int'(y), 'hF8);
         check($sformatf("bp.hold%0d.in_ready", i), int'(in_ready), 0);
         check($sformatf("bp.hold%0d.out_valid", i), int'(out_valid), 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp.release.in_ready", int'(in_ready), 1);
      check("bp.release.out_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp.xor.out_valid", int'(out_valid), 1);
      check("bp.xor.y", int'(y), 'h0F);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset mid-multiply, with a non-zero divide-by-zero result still registered.
      verify("pre_rst", 8'd9, 8'd0, 3'd3, 8'hFF, 8'h09, 4'b0001, 0);
      a = 8'd200; b = 8'd200; op = 3'd2; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("mrst.busy.out_valid", int'(out_valid), 0);
      check("mrst.busy.in_ready", int'(in_ready), 0);
      rst_n = 1'b0;
      #1;
      check("mrst.y", int'(y), 0);
      check("mrst.hi", int'(hi), 0);
      check("mrst.flags", int'({zero, carry, ovf, dz}), 0);
      check("mrst.out_valid", int'(out_valid), 0);
      check("mrst.in_ready", int'(in_ready), 1);
      @(posedge clk); #2;
      rst_n = 1'b1;
      #1 check("mrst.release.in_ready", int'(in_ready), 1);
      verify("post_rst_mul", 8'd6, 8'd7, 3'd2, 8'd42, 8'h00, 4'b0000, 8);

      for (int i = 0; i < 150; i++) begin
         ra  = W'($urandom);
         rb  = ($urandom_range(7, 0) == 0) ? '0 : W'($urandom);
         rop = 3'($urandom_range(7, 0));
         model(ra, rb, rop, ey, ehi, ef, elat);
         verify($sformatf("rnd%0d_op%0d", i, rop), ra, rb, rop, ey, ehi, ef, elat);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
